product_accumulator: RTL

Accumulation stage directly downstream of `array_multiplier`. It consumes the registered 16-bit product stream (`Z_reg` qualified by `o_valid`), sums a programmable number of consecutive products into one frame result, and emits each frame sum with a one-cycle valid pulse. It is the reduction half of a multiply-accumulate datapath. It never backpressures, because the multiplier has no ready input.

---
 rtl/product_accumulator_if.sv | 18 +
 rtl/product_accumulator.sv | 65 ++++++
 2 files changed

// File: rtl/product_accumulator_if.sv
// product_accumulator_if: product stream in, frame results out
interface product_accumulator_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 8
);
  logic              i_valid;
  logic [PROD_W-1:0] i_prod;
  logic [LEN_W-1:0]  i_len;
  logic              i_clear;
  logic              o_valid;
  logic [ACC_W-1:0]  o_sum;
  logic              o_ovf;
  logic              o_busy;
  logic [7:0]        o_frame_cnt;
  modport master (output i_valid, i_prod, i_len, i_clear, input o_valid, o_sum, o_ovf, o_busy, o_frame_cnt);
  modport slave  (input i_valid, i_prod, i_len, i_clear, output o_valid, o_sum, o_ovf, o_busy, o_frame_cnt);
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums a programmable number of products per frame with saturation
module product_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 8
) (
  input logic clk,
  input logic rst_n,
  product_accumulator_if.slave bus
);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, fin_acc;
  logic [LEN_W:0]   cnt, len_q, len_in, len_use, fin_cnt;
  logic             sat, fin_sat, accept, done;
  logic [ACC_W:0]   sum_w;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state and the values a frame would hold after accepting this product
  always_comb begin
    len_in   = (bus.i_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, bus.i_len};
    len_use  = (state == IDLE) ? len_in : len_q;
    sum_w    = {1'b0, acc} + (ACC_W+1)'(bus.i_prod);
    fin_acc  = (state == IDLE) ? ACC_W'(bus.i_prod) : (sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0]);
    fin_sat  = (state == IDLE) ? 1'b0 : (sat | sum_w[ACC_W]);
    fin_cnt  = (state == IDLE) ? (LEN_W+1)'(1) : cnt + 1'b1;
    accept   = bus.i_valid & ~bus.i_clear;
    done     = accept & (fin_cnt == len_use);
    state_nx = bus.i_clear ? IDLE : (accept ? (done ? IDLE : ACCUM) : state);
  end
  // accumulation datapath; a completed or aborted frame leaves it zeroed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
      len_q <= '0;
    end else if (bus.i_clear) begin
      acc <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (accept) begin
      acc   <= done ? '0 : fin_acc;
      cnt   <= done ? '0 : fin_cnt;
      sat   <= done ? 1'b0 : fin_sat;
      len_q <= (state == IDLE) ? len_in : len_q;
    end
  // registered result outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.o_valid     <= 1'b0;
      bus.o_sum       <= '0;
      bus.o_ovf       <= 1'b0;
      bus.o_busy      <= 1'b0;
      bus.o_frame_cnt <= '0;
    end else begin
      bus.o_valid     <= done;
      bus.o_busy      <= (state_nx == ACCUM);
      bus.o_sum       <= done ? fin_acc : bus.o_sum;
      bus.o_ovf       <= done ? fin_sat : bus.o_ovf;
      bus.o_frame_cnt <= bus.o_frame_cnt + {7'd0, done};
    end
endmodule
